// File: rtl/fsqrt_pipe.sv
// Pipelined single-precision square root: seed table, ITERS Newton steps on 1/sqrt(m),
// final y = m*x with round-to-nearest-even. Whole pipe stalls on output back-pressure.
module fsqrt_pipe #(
  parameter int ITERS     = 2,
  parameter int TAG_W     = 5,
  parameter int SEED_BITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inv
);
  localparam int SW    = SEED_BITS + 1;
  localparam int NSEED = 1 << SW;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Seed S ~ 1/sqrt(m_mid) in units of 2^-SW, found by integer binary search at elaboration.
  function automatic logic [SW-1:0] seed_calc(input int idx);
    longint top, mm, lim, lo, hi, mid, s;
    top = longint'(1) << SW;
    mm  = top + 2 * longint'(idx % (1 << SEED_BITS)) + 1;
    if (idx >= (1 << SEED_BITS)) mm = mm * 2;
    lim = longint'(1) << (3 * SEED_BITS + 5);
    lo  = 0;
    hi  = top * 2;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid * mm <= lim) lo = mid;
      else hi = mid - 1;
    end
    s = (lo + 1) >> 1;
    if (s > top - 1) s = top - 1;
    return s[SW-1:0];
  endfunction

  // x' = (3x - m*x^3)/2; m is Q2.31, x is Q1.31, products truncated.
  function automatic logic [31:0] newton(input logic [32:0] m, input logic [31:0] x);
    logic [63:0] x2, mx2, t, tx;
    x2  = (64'(x) * 64'(x)) >> 31;
    mx2 = (64'(m) * x2) >> 31;
    t   = (mx2 * 64'(x)) >> 31;
    tx  = 64'(x) * 64'd3;
    return 32'((tx - t) >> 1);
  endfunction

  logic [SW-1:0] seed_rom [NSEED];
  for (genvar gi = 0; gi < NSEED; gi++) begin : g_rom
    localparam logic [SW-1:0] SEED_V = seed_calc(gi);
    assign seed_rom[gi] = SEED_V;
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [7:0]        in_e;
  logic [22:0]       in_f;
  logic              odd_exp;
  logic signed [9:0] e_unb, e_half;
  logic              s0_spec, s0_inv;
  logic [31:0]       s0_sval, s0_x;
  logic [32:0]       s0_m;
  logic [7:0]        s0_e;

  always_comb begin
    in_e    = in_data[30:23];
    in_f    = in_data[22:0];
    odd_exp = ~in_e[0];
    e_unb   = $signed({2'b00, in_e}) - 10'sd127;
    e_half  = e_unb >>> 1;
    s0_e    = 8'(e_half + 10'sd127);
    s0_m    = odd_exp ? {1'b1, in_f, 9'b0} : {2'b01, in_f, 8'b0};
    s0_x    = {1'b0, seed_rom[{odd_exp, in_f[22 -: SEED_BITS]}], {(31 - SW){1'b0}}};
    s0_spec = 1'b1;
    s0_inv  = 1'b0;
    s0_sval = '0;
    if (in_e == 8'hFF) begin
      if (in_f != '0 || in_data[31]) begin
        s0_sval = QNAN;
        s0_inv  = 1'b1;
      end else begin
        s0_sval = 32'h7F800000;
      end
    end else if (in_e == 8'h00) begin
      s0_sval = {in_data[31], 31'b0};
    end else if (in_data[31]) begin
      s0_sval = QNAN;
      s0_inv  = 1'b1;
    end else begin
      s0_spec = 1'b0;
    end
  end

  logic             v_reg    [ITERS+1];
  logic [TAG_W-1:0] tag_reg  [ITERS+1];
  logic             spec_reg [ITERS+1];
  logic             inv_reg  [ITERS+1];
  logic [31:0]      sval_reg [ITERS+1];
  logic [32:0]      m_reg    [ITERS+1];
  logic [31:0]      x_reg    [ITERS+1];
  logic [7:0]       e_reg    [ITERS+1];
  logic [31:0]      x_next   [ITERS+1];

  assign x_next[0] = s0_x;
  for (genvar gi = 1; gi <= ITERS; gi++) begin : g_newton
    assign x_next[gi] = newton(m_reg[gi-1], x_reg[gi-1]);
  end

  // y = m*x sits just below sqrt(m); a y < 1 is renormalised and usually rounds back up.
  logic [31:0] y, norm, res;
  logic [24:0] sum;
  logic        up;
  logic [7:0]  e_fin;
  logic [22:0] frac;

  always_comb begin
    y     = 32'((64'(m_reg[ITERS]) * 64'(x_reg[ITERS])) >> 31);
    norm  = y[31] ? y : {y[30:0], 1'b0};
    up    = norm[7] & (norm[6] | (|norm[5:0]) | norm[8]);
    sum   = {1'b0, norm[31:8]} + {24'b0, up};
    e_fin = e_reg[ITERS] - {7'b0, ~y[31]} + {7'b0, sum[24]};
    frac  = sum[24] ? sum[23:1] : sum[22:0];
    res   = spec_reg[ITERS] ? sval_reg[ITERS] : {1'b0, e_fin, frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= ITERS; k++) begin
        v_reg[k]    <= 1'b0;
        tag_reg[k]  <= '0;
        spec_reg[k] <= 1'b0;
        inv_reg[k]  <= 1'b0;
        sval_reg[k] <= '0;
        m_reg[k]    <= '0;
        x_reg[k]    <= '0;
        e_reg[k]    <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_inv   <= 1'b0;
    end else if (en) begin
      v_reg[0]    <= in_valid;
      tag_reg[0]  <= in_tag;
      spec_reg[0] <= s0_spec;
      inv_reg[0]  <= s0_inv;
      sval_reg[0] <= s0_sval;
      m_reg[0]    <= s0_m;
      e_reg[0]    <= s0_e;
      for (int k = 0; k <= ITERS; k++) x_reg[k] <= x_next[k];
      for (int k = 1; k <= ITERS; k++) begin
        v_reg[k]    <= v_reg[k-1];
        tag_reg[k]  <= tag_reg[k-1];
        spec_reg[k] <= spec_reg[k-1];
        inv_reg[k]  <= inv_reg[k-1];
        sval_reg[k] <= sval_reg[k-1];
        m_reg[k]    <= m_reg[k-1];
        e_reg[k]    <= e_reg[k-1];
      end
      out_valid <= v_reg[ITERS];
      out_data  <= res;
      out_tag   <= tag_reg[ITERS];
      out_inv   <= inv_reg[ITERS];
    end
  end
endmodule

// File: tb/tb_fsqrt_pipe.sv
// Scoreboard bench for fsqrt_pipe: expected results come from a real-arithmetic sqrt
// model rounded to single precision; a separate monitor pops and compares.
`timescale 1ns/1ps
module tb_fsqrt_pipe;
  localparam int ITERS = 2;
  localparam int TAG_W = 5;
  localparam int L     = ITERS + 2;

  logic             clk = 1'b0, rst = 1'b1;
  logic             in_valid = 1'b0, out_ready = 1'b1;
  logic             in_ready, out_valid, out_inv;
  logic [31:0]      in_data = '0, out_data;
  logic [TAG_W-1:0] in_tag = '0, out_tag;

  fsqrt_pipe #(.ITERS(ITERS), .TAG_W(TAG_W), .SEED_BITS(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_inv(out_inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      op;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             inv;
    int               tol;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, txn = 0;
  bit   bp_random = 0;

  // Returns {inv, result}: specials by rule, normals via double sqrt rounded to nearest-even.
  function automatic logic [32:0] ref_sqrt(input logic [31:0] s);
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] b;
    real         r;
    int          ex;
    logic [24:0] mant;
    logic [28:0] rem;
    e = s[30:23];
    f = s[22:0];
    if (e == 8'hFF) return (f != 0 || s[31]) ? {1'b1, 32'h7FC00000} : {1'b0, 32'h7F800000};
    if (e == 8'h00) return {1'b0, s[31], 31'b0};
    if (s[31]) return {1'b1, 32'h7FC00000};
    b    = {1'b0, 11'(int'(e) - 127 + 1023), f, 29'b0};
    r    = $sqrt($bitstoreal(b));
    b    = $realtobits(r);
    ex   = int'(b[62:52]) - 1023 + 127;
    mant = {2'b01, b[51:29]};
    rem  = b[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      ex++;
    end
    return {1'b0, 1'b0, 8'(ex), mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] op, input logic [TAG_W-1:0] tag,
                      input logic [31:0] exp_d, input logic exp_inv, input int tol);
    exp_t e;
    int   n;
    bit   ok;
    e.op = op; e.data = exp_d; e.tag = tag; e.inv = exp_inv; e.tol = tol;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = op;
    in_tag   = tag;
    n  = 0;
    ok = 0;
    while (!ok) begin
      #1;
      ok = in_ready;
      if (ok) sb.push_back(e);
      @(posedge clk);
      if (!ok) begin
        n++;
        if (n > 500) begin
          checks++;
          errors++;
          $display("FAIL send_timeout op %h in_ready stuck at %b", op, in_ready);
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic send_model(input logic [31:0] op, input logic [TAG_W-1:0] tag);
    logic [32:0] r;
    bit          normal_pos;
    r = ref_sqrt(op);
    normal_pos = (op[30:23] != 8'h00) && (op[30:23] != 8'hFF) && !op[31];
    send(op, tag, r[31:0], r[32], normal_pos ? 1 : 0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: samples between edges, after the bench has settled its inputs.
  logic             held = 1'b0, held_inv;
  logic [31:0]      held_data;
  logic [TAG_W-1:0] held_tag;

  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (out_data !== held_data || out_tag !== held_tag || out_inv !== held_inv) begin
          errors++;
          $display("FAIL hold_stable got %h/%0d/%b required %h/%0d/%b",
                   out_data, out_tag, out_inv, held_data, held_tag, held_inv);
        end
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready got %b required 0", in_ready);
        end
        held = 1'b1; held_data = out_data; held_tag = out_tag; held_inv = out_inv;
      end
      if (out_valid && out_ready) begin
        checks++;
        txn++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h tag %0d required no output", out_data, out_tag);
        end else begin
          exp_t   e;
          longint diff;
          e    = sb.pop_front();
          diff = longint'(out_data) - longint'(e.data);
          if (diff < 0) diff = -diff;
          if ($isunknown({out_data, out_tag, out_inv}) || out_tag !== e.tag ||
              out_inv !== e.inv || diff > longint'(e.tol)) begin
            errors++;
            $display("FAIL result op %h got %h tag %0d inv %b required %h tag %0d inv %b tol %0d",
                     e.op, out_data, out_tag, out_inv, e.data, e.tag, e.inv, e.tol);
          end else begin
            $display("txn %0d op %h -> %h tag %0d inv %b", txn, e.op, out_data, out_tag, out_inv);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks %0d", checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_op  [11];
  logic [31:0] dir_exp [11];
  logic        dir_inv [11];

  initial begin
    dir_op  = '{32'h40000000, 32'h3E800000, 32'h3F800000, 32'h41C80000, 32'hBF800000, 32'h7F800000,
                32'h80000000, 32'h00000001, 32'h7FC00001, 32'hFF800000, 32'h00000000};
    dir_exp = '{32'h3FB504F3, 32'h3F000000, 32'h3F800000, 32'h40A00000, 32'h7FC00000, 32'h7F800000,
                32'h80000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
    dir_inv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_out_inv", 32'(out_inv), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: 4.0 -> 2.0 appears exactly L cycles after the transfer
    send(32'h40800000, 5'd3, 32'h40000000, 1'b0, 0);
    for (int k = 1; k <= L; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
      chk($sformatf("latency_cycle%0d", k), 32'(out_valid), (k == L) ? 32'd1 : 32'd0);
    end
    drain();

    // Directed values and special operands, back to back
    for (int i = 0; i < 11; i++) send(dir_op[i], TAG_W'(i + 8), dir_exp[i], dir_inv[i], 0);
    idle();
    drain();

    // Stream of 16 with a 5-cycle output stall in the middle
    fork
      for (int i = 0; i < 16; i++)
        send_model({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, TAG_W'(i));
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Reset with three operands in flight
    send_model(32'h40400000, 5'd1);
    send_model(32'h41000000, 5'd2);
    send_model(32'h42000000, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    for (int k = 0; k < L; k++) begin
      #1;
      chk($sformatf("post_reset_quiet%0d", k), 32'(out_valid), 32'd0);
      @(negedge clk);
      if (k == 1) rst = 1'b0;
    end
    send(32'h41100000, 5'd7, 32'h40400000, 1'b0, 0);
    idle();
    drain();

    // Random sweep with random back-pressure; mostly positive normals, some arbitrary words
    bp_random = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) send_model($urandom, TAG_W'($urandom));
      else send_model({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, TAG_W'($urandom));
    end
    idle();
    bp_random = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
